// File: rtl/axi4_config_master.sv
// Single-outstanding AXI4 master: one local request becomes one single-beat
// AXI4 write (AW/W/B) or read (AR/R), followed by one local response.
module axi4_config_master #(
    parameter int                     MST_ID_W     = 5,
    parameter logic [MST_ID_W-1:0]    MST_ID       = '0,
    parameter int                     DATA_W       = 8,
    parameter int                     ADDR_W       = 32,
    parameter int                     TRANS_RESP_W = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_wr_i,
    input  logic [ADDR_W-1:0]       req_addr_i,
    input  logic [DATA_W-1:0]       req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic                    rsp_wr_o,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    output logic [TRANS_RESP_W-1:0] rsp_resp_o,
    output logic [MST_ID_W-1:0]     m_awid_o,
    output logic [ADDR_W-1:0]       m_awaddr_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [DATA_W-1:0]       m_wdata_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    input  logic [TRANS_RESP_W-1:0] m_bresp_i,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    output logic [MST_ID_W-1:0]     m_arid_o,
    output logic [ADDR_W-1:0]       m_araddr_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    input  logic [DATA_W-1:0]       m_rdata_i,
    input  logic [TRANS_RESP_W-1:0] m_rresp_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [TRANS_RESP_W-1:0] resp_q, resp_d;
    logic                    wr_q, wr_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    aw_fire, w_fire;

    assign aw_fire = awvalid_q & m_awready_i;
    assign w_fire  = wvalid_q & m_wready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        wr_d      = wr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    wr_d    = req_wr_i;
                    if (req_wr_i) begin
                        state_d   = WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently, in either order or together
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_fire) && (w_done_q | w_fire)) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_bvalid_i) begin
                    resp_d   = m_bresp_i;
                    rdata_d  = '0;
                    bready_d = 1'b0;
                    state_d  = RSP;
                end
            end
            RD_REQ: begin
                if (arvalid_q && m_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_rvalid_i) begin
                    rdata_d  = m_rdata_i;
                    resp_d   = m_rresp_i;
                    rready_d = 1'b0;
                    state_d  = RSP;
                end
            end
            RSP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            wr_q      <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            wr_q      <= wr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RSP);
    assign rsp_wr_o    = wr_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_resp_o  = resp_q;
    assign m_awid_o    = MST_ID;
    assign m_arid_o    = MST_ID;
    assign m_awaddr_o  = addr_q;
    assign m_araddr_o  = addr_q;
    assign m_wdata_o   = wdata_q;
    assign m_awvalid_o = awvalid_q;
    assign m_wvalid_o  = wvalid_q;
    assign m_arvalid_o = arvalid_q;
    assign m_bready_o  = bready_q;
    assign m_rready_o  = rready_q;

endmodule

// File: tb/tb_axi4_config_master.sv
// Bench for axi4_config_master: a delay-configurable AXI slave with its own
// storage, directed scenarios, and randomized traffic checked against a memory model.
module tb_axi4_config_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_ready_o, req_wr_i;
    logic [31:0] req_addr_i;
    logic [7:0]  req_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_wr_o;
    logic [7:0]  rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic [4:0]  m_awid_o, m_arid_o;
    logic [31:0] m_awaddr_o, m_araddr_o;
    logic        m_awvalid_o, m_awready_i;
    logic [7:0]  m_wdata_o;
    logic        m_wvalid_o, m_wready_i;
    logic [1:0]  m_bresp_i;
    logic        m_bvalid_i, m_bready_o;
    logic        m_arvalid_o, m_arready_i;
    logic [7:0]  m_rdata_i;
    logic [1:0]  m_rresp_i;
    logic        m_rvalid_i, m_rready_o;

    int total = 0;
    int bad   = 0;

    axi4_config_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_wr_o(rsp_wr_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
        .m_awid_o(m_awid_o), .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o),
        .m_awready_i(m_awready_i), .m_wdata_o(m_wdata_o), .m_wvalid_o(m_wvalid_o),
        .m_wready_i(m_wready_i), .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i),
        .m_bready_o(m_bready_o), .m_arid_o(m_arid_o), .m_araddr_o(m_araddr_o),
        .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_rdata_i(m_rdata_i),
        .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
    );

    always #5 clk = ~clk;

    // ---------------- AXI slave environment ----------------
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic [31:0] slv_awaddr, slv_araddr;
    logic [7:0]  slv_wdata;
    logic [7:0]  slv_mem [logic [31:0]];

    function automatic bit unmapped(input logic [31:0] a);
        return a >= 32'h3000_0100;
    endfunction

    // Readies/valids change on the falling edge; a ready raised here means the
    // handshake happens on the next rising edge, so the payload is captured now.
    initial begin
        m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bresp_i = 0;
        m_arready_i = 0; m_rvalid_i = 0; m_rdata_i = 0; m_rresp_i = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0;
                m_arready_i = 0; m_rvalid_i = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (m_awvalid_o) begin
                    if (aw_cnt >= aw_dly) begin m_awready_i = 1; slv_awaddr = m_awaddr_o; end
                    else begin m_awready_i = 0; aw_cnt++; end
                end else begin m_awready_i = 0; aw_cnt = 0; end
                if (m_wvalid_o) begin
                    if (w_cnt >= w_dly) begin m_wready_i = 1; slv_wdata = m_wdata_o; end
                    else begin m_wready_i = 0; w_cnt++; end
                end else begin m_wready_i = 0; w_cnt = 0; end
                if (m_bready_o) begin
                    if (b_cnt >= b_dly) begin
                        if (!m_bvalid_i) begin
                            m_bresp_i = unmapped(slv_awaddr) ? 2'b11 : 2'b00;
                            if (!unmapped(slv_awaddr)) slv_mem[slv_awaddr] = slv_wdata;
                        end
                        m_bvalid_i = 1;
                    end else b_cnt++;
                end else begin m_bvalid_i = 0; b_cnt = 0; end
                if (m_arvalid_o) begin
                    if (ar_cnt >= ar_dly) begin m_arready_i = 1; slv_araddr = m_araddr_o; end
                    else begin m_arready_i = 0; ar_cnt++; end
                end else begin m_arready_i = 0; ar_cnt = 0; end
                if (m_rready_o) begin
                    if (r_cnt >= r_dly) begin
                        m_rvalid_i = 1;
                        m_rresp_i  = unmapped(slv_araddr) ? 2'b11 : 2'b00;
                        m_rdata_i  = (!unmapped(slv_araddr) && slv_mem.exists(slv_araddr))
                                     ? slv_mem[slv_araddr] : 8'h00;
                    end else r_cnt++;
                end else begin m_rvalid_i = 0; r_cnt = 0; end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] mdl [logic [31:0]];

    // Generic transaction driver: returns the response fields, ok=0 on timeout.
    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic [1:0] rs, output logic rw,
                          output bit ok);
        int n;
        ok = 1; rd = 'x; rs = 'x; rw = 'x;
        @(negedge clk);
        req_valid_i = 1; req_wr_i = wr; req_addr_i = a; req_wdata_i = d;
        n = 0;
        while (!req_ready_o && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) ok = 0;
        @(negedge clk);
        req_valid_i = 0;
        n = 0;
        while (!rsp_valid_o && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) ok = 0;
        rd = rsp_rdata_o; rs = rsp_resp_o; rw = rsp_wr_o;
        rsp_ready_i = 1;
        @(negedge clk);
        rsp_ready_i = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        total++;
        if ({req_ready_o, rsp_valid_o, m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=1000000",
                     {req_ready_o, rsp_valid_o, m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o});
        end
        total++;
        if (m_awid_o !== 5'd0 || m_arid_o !== 5'd0 || m_awaddr_o !== 32'h0 || rsp_rdata_o !== 8'h0 || rsp_resp_o !== 2'b00) begin
            bad++;
            $display("FAIL reset_data awid=%h arid=%h awaddr=%h rdata=%h resp=%b want all 0",
                     m_awid_o, m_arid_o, m_awaddr_o, rsp_rdata_o, rsp_resp_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        aw_dly = 0; w_dly = 0; b_dly = 0;
        @(negedge clk);
        req_valid_i = 1; req_wr_i = 1; req_addr_i = 32'h3000_0004; req_wdata_i = 8'h12;
        total++;
        if (req_ready_o !== 1'b1) begin bad++; $display("FAIL wr_accept ready=%b want=1", req_ready_o); end
        @(negedge clk);  // cycle 1
        req_valid_i = 0;
        total++;
        if (m_awvalid_o !== 1 || m_wvalid_o !== 1 || m_awaddr_o !== 32'h3000_0004 || m_wdata_o !== 8'h12 || req_ready_o !== 0) begin
            bad++;
            $display("FAIL wr_cycle1 awv=%b wv=%b awaddr=%h wdata=%h rdy=%b want 1 1 30000004 12 0",
                     m_awvalid_o, m_wvalid_o, m_awaddr_o, m_wdata_o, req_ready_o);
        end
        @(negedge clk);  // cycle 2
        total++;
        if (m_bready_o !== 1 || m_awvalid_o !== 0 || m_wvalid_o !== 0 || rsp_valid_o !== 0) begin
            bad++;
            $display("FAIL wr_cycle2 bready=%b awv=%b wv=%b rspv=%b want 1 0 0 0", m_bready_o, m_awvalid_o, m_wvalid_o, rsp_valid_o);
        end
        @(negedge clk);  // cycle 3
        total++;
        if (rsp_valid_o !== 1 || rsp_wr_o !== 1 || rsp_resp_o !== 2'b00 || rsp_rdata_o !== 8'h00 || m_bready_o !== 0) begin
            bad++;
            $display("FAIL wr_cycle3 rspv=%b wr=%b resp=%b rdata=%h bready=%b want 1 1 00 00 0",
                     rsp_valid_o, rsp_wr_o, rsp_resp_o, rsp_rdata_o, m_bready_o);
        end
        rsp_ready_i = 1;
        @(negedge clk);
        rsp_ready_i = 0;
        total++;
        if (rsp_valid_o !== 0 || req_ready_o !== 1) begin
            bad++; $display("FAIL wr_done rspv=%b rdy=%b want 0 1", rsp_valid_o, req_ready_o);
        end
        mdl[32'h3000_0004] = 8'h12;
    endtask

    task automatic test_read_basic();
        logic [7:0] rd; logic [1:0] rs; logic rw; bit ok;
        ar_dly = 0; r_dly = 0;
        @(negedge clk);
        req_valid_i = 1; req_wr_i = 0; req_addr_i = 32'h3000_0004; req_wdata_i = 8'hAA;
        @(negedge clk);
        req_valid_i = 0;
        total++;
        if (m_arvalid_o !== 1 || m_araddr_o !== 32'h3000_0004 || m_awvalid_o !== 0) begin
            bad++; $display("FAIL rd_ar arv=%b araddr=%h awv=%b want 1 30000004 0", m_arvalid_o, m_araddr_o, m_awvalid_o);
        end
        @(negedge clk);
        total++;
        if (m_rready_o !== 1 || m_arvalid_o !== 0) begin
            bad++; $display("FAIL rd_rready rready=%b arv=%b want 1 0", m_rready_o, m_arvalid_o);
        end
        @(negedge clk);
        total++;
        if (rsp_valid_o !== 1 || rsp_wr_o !== 0 || rsp_rdata_o !== 8'h12 || rsp_resp_o !== 2'b00) begin
            bad++; $display("FAIL rd_rsp rspv=%b wr=%b rdata=%h resp=%b want 1 0 12 00", rsp_valid_o, rsp_wr_o, rsp_rdata_o, rsp_resp_o);
        end
        rsp_ready_i = 1;
        @(negedge clk);
        rsp_ready_i = 0;
        ok = 1; rd = 0; rs = 0; rw = 0;
    endtask

    task automatic test_aw_delay();
        int rsp_cnt;
        aw_dly = 3; w_dly = 0; b_dly = 0;
        @(negedge clk);
        req_valid_i = 1; req_wr_i = 1; req_addr_i = 32'h3000_0008; req_wdata_i = 8'h5C;
        @(negedge clk);  // cycle 1
        req_valid_i = 0;
        total++;
        if (m_awvalid_o !== 1 || m_wvalid_o !== 1) begin
            bad++; $display("FAIL awdly_c1 awv=%b wv=%b want 1 1", m_awvalid_o, m_wvalid_o);
        end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            total++;
            if (m_wvalid_o !== 0 || m_awvalid_o !== 1 || m_awaddr_o !== 32'h3000_0008 || m_bready_o !== 0) begin
                bad++;
                $display("FAIL awdly_hold c=%0d wv=%b awv=%b awaddr=%h bready=%b want 0 1 30000008 0",
                         c, m_wvalid_o, m_awvalid_o, m_awaddr_o, m_bready_o);
            end
        end
        @(negedge clk);  // cycle 5
        total++;
        if (m_awvalid_o !== 0 || m_bready_o !== 1) begin
            bad++; $display("FAIL awdly_c5 awv=%b bready=%b want 0 1", m_awvalid_o, m_bready_o);
        end
        rsp_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid_o) begin rsp_cnt++; rsp_ready_i = 1; end
            else rsp_ready_i = 0;
        end
        rsp_ready_i = 0;
        total++;
        if (rsp_cnt !== 1) begin bad++; $display("FAIL awdly_rspcount got=%0d want=1", rsp_cnt); end
        mdl[32'h3000_0008] = 8'h5C;
        aw_dly = 0;
    endtask

    task automatic test_decode_err();
        logic [7:0] rd; logic [1:0] rs; logic rw; bit ok;
        do_txn(1'b1, 32'h3000_0100, 8'h77, rd, rs, rw, ok);
        total++;
        if (!ok || rs !== 2'b11 || rw !== 1'b1) begin
            bad++; $display("FAIL decerr_wr ok=%0d resp=%b wr=%b want 1 11 1", ok, rs, rw);
        end
        do_txn(1'b0, 32'h3000_0100, 8'h00, rd, rs, rw, ok);
        total++;
        if (!ok || rs !== 2'b11 || rw !== 1'b0 || rd !== 8'h00) begin
            bad++; $display("FAIL decerr_rd ok=%0d resp=%b wr=%b rdata=%h want 1 11 0 00", ok, rs, rw, rd);
        end
    endtask

    task automatic test_rsp_backpressure();
        int n;
        logic [7:0] rd0; logic [1:0] rs0; logic rw0;
        @(negedge clk);
        req_valid_i = 1; req_wr_i = 1; req_addr_i = 32'h3000_000C; req_wdata_i = 8'h3E;
        @(negedge clk);
        req_wr_i = 0; req_addr_i = 32'h3000_000C;  // queued follow-up read, held valid
        n = 0;
        while (!rsp_valid_o && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL bp_timeout rspv=%b want 1", rsp_valid_o); end
        rd0 = rsp_rdata_o; rs0 = rsp_resp_o; rw0 = rsp_wr_o;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (rsp_valid_o !== 1 || req_ready_o !== 0 || rsp_rdata_o !== rd0 || rsp_resp_o !== rs0 || rsp_wr_o !== rw0 || rw0 !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold c=%0d rspv=%b rdy=%b wr=%b resp=%b want 1 0 1 stable", c, rsp_valid_o, req_ready_o, rsp_wr_o, rsp_resp_o);
            end
            @(negedge clk);
        end
        rsp_ready_i = 1;
        @(negedge clk);
        rsp_ready_i = 0;
        total++;
        if (req_ready_o !== 1 || rsp_valid_o !== 0) begin
            bad++; $display("FAIL bp_release rdy=%b rspv=%b want 1 0", req_ready_o, rsp_valid_o);
        end
        @(negedge clk);
        req_valid_i = 0;
        total++;
        if (m_arvalid_o !== 1 || req_ready_o !== 0) begin
            bad++; $display("FAIL bp_next_accept arv=%b rdy=%b want 1 0", m_arvalid_o, req_ready_o);
        end
        n = 0;
        while (!rsp_valid_o && n < 50) begin @(negedge clk); n++; end
        total++;
        if (rsp_valid_o !== 1 || rsp_rdata_o !== 8'h3E || rsp_wr_o !== 0) begin
            bad++; $display("FAIL bp_readback rspv=%b rdata=%h wr=%b want 1 3e 0", rsp_valid_o, rsp_rdata_o, rsp_wr_o);
        end
        rsp_ready_i = 1;
        @(negedge clk);
        rsp_ready_i = 0;
        mdl[32'h3000_000C] = 8'h3E;
    endtask

    task automatic test_reset_mid();
        b_dly = 10;
        @(negedge clk);
        req_valid_i = 1; req_wr_i = 1; req_addr_i = 32'h3000_0000; req_wdata_i = 8'h99;
        @(negedge clk);
        req_valid_i = 0;
        @(negedge clk);
        total++;
        if (m_bready_o !== 1) begin bad++; $display("FAIL rstmid_bready got=%b want=1", m_bready_o); end
        rst_n = 0;
        #1;
        total++;
        if ({m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o, rsp_valid_o} !== 6'b0) begin
            bad++;
            $display("FAIL rstmid_outs got=%b want=000000", {m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o, rsp_valid_o});
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        total++;
        if (req_ready_o !== 1 || rsp_valid_o !== 0) begin
            bad++; $display("FAIL rstmid_release rdy=%b rspv=%b want 1 0", req_ready_o, rsp_valid_o);
        end
        b_dly = 0;
    endtask

    task automatic test_random();
        logic [31:0] addrs [5];
        logic [7:0] rd; logic [1:0] rs; logic rw; bit ok;
        logic [31:0] a; logic [7:0] d; logic wr;
        logic [7:0] exp_rd; logic [1:0] exp_rs;
        addrs[0] = 32'h3000_0000; addrs[1] = 32'h3000_0004; addrs[2] = 32'h3000_0008;
        addrs[3] = 32'h3000_000C; addrs[4] = 32'h3000_0100;
        for (int i = 0; i < 40; i++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            a  = addrs[$urandom_range(0, 4)];
            d  = 8'($urandom);
            wr = 1'($urandom);
            exp_rs = (a == 32'h3000_0100) ? 2'b11 : 2'b00;
            if (wr) exp_rd = 8'h00;
            else if (a == 32'h3000_0100 || !mdl.exists(a)) exp_rd = 8'h00;
            else exp_rd = mdl[a];
            do_txn(wr, a, d, rd, rs, rw, ok);
            if (wr && a != 32'h3000_0100) mdl[a] = d;
            total++;
            if (!ok || rw !== wr || rs !== exp_rs || rd !== exp_rd) begin
                bad++;
                $display("FAIL rand%0d addr=%h wr=%b got ok=%0d wr=%b resp=%b rdata=%h want wr=%b resp=%b rdata=%h",
                         i, a, wr, ok, rw, rs, rd, wr, exp_rs, exp_rd);
            end
        end
    endtask

    initial begin
        req_valid_i = 0; req_wr_i = 0; req_addr_i = 0; req_wdata_i = 0; rsp_ready_i = 0;
        test_reset();
        test_write_basic();
        test_read_basic();
        test_aw_delay();
        test_decode_err();
        test_rsp_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
